// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Multi-cycle multiply/divide unit with HI/LO registers.
//               mult/multu hold Busy for MULT_CYCLES and div/divu for
//               DIV_CYCLES. mthi/mtlo complete in one cycle. A result is
//               written to HI/LO on the edge where Busy falls.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Occupied,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    logic [1:0]         r_state,  w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic               r_signed, w_signed_nxt;
    logic [31:0]        r_a,      w_a_nxt;
    logic [31:0]        r_b,      w_b_nxt;
    logic [31:0]        r_hi,     w_hi_nxt;
    logic [31:0]        r_lo,     w_lo_nxt;
    logic               r_busy;

    // Product from the latched operands; sign-extension selects mult vs multu.
    logic [63:0] w_ext_a, w_ext_b, w_prod;
    assign w_ext_a = {{32{r_signed & r_a[31]}}, r_a};
    assign w_ext_b = {{32{r_signed & r_b[31]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed division is done on magnitudes and corrected afterwards so that
    // the quotient truncates toward zero and the remainder follows the dividend.
    logic [31:0] w_mag_a, w_mag_b, w_div_b, w_uq, w_ur, w_quot, w_rem;
    logic        w_neg_q, w_neg_r;
    assign w_neg_r = r_signed & r_a[31];
    assign w_neg_q = r_signed & (r_a[31] ^ r_b[31]);
    assign w_mag_a = w_neg_r ? (32'd0 - r_a) : r_a;
    assign w_mag_b = (r_signed & r_b[31]) ? (32'd0 - r_b) : r_b;
    // Keep the divider's operand non-zero; a zero divisor never writes back.
    assign w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq    = w_mag_a / w_div_b;
    assign w_ur    = w_mag_a % w_div_b;
    assign w_quot  = w_neg_q ? (32'd0 - w_uq) : w_uq;
    assign w_rem   = w_neg_r ? (32'd0 - w_ur) : w_ur;

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_signed_nxt = r_signed;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        case (r_state)
            c_ST_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        c_OP_MULT, c_OP_MULTU: begin
                            w_state_nxt  = c_ST_MUL;
                            w_cnt_nxt    = c_MULT_LOAD;
                            w_signed_nxt = (MDUOp == c_OP_MULT);
                            w_a_nxt      = A;
                            w_b_nxt      = B;
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            w_state_nxt  = c_ST_DIV;
                            w_cnt_nxt    = c_DIV_LOAD;
                            w_signed_nxt = (MDUOp == c_OP_DIV);
                            w_a_nxt      = A;
                            w_b_nxt      = B;
                        end
                        c_OP_MTHI: w_hi_nxt = A;
                        c_OP_MTLO: w_lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            c_ST_MUL, c_ST_DIV: begin
                // The count of 1 marks the last Busy cycle: results land on this edge.
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                    if (r_state == c_ST_MUL) begin
                        w_hi_nxt = w_prod[63:32];
                        w_lo_nxt = w_prod[31:0];
                    end else if (r_b != 32'd0) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quot;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation and ignores a same-cycle Start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_signed <= w_signed_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_busy   <= (w_state_nxt != c_ST_IDLE);
        end
    end

    assign Busy     = r_busy;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign Occupied = r_busy | (Start & (MDUOp >= c_OP_MULT) & (MDUOp <= c_OP_DIVU));

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Directed self-checking bench for the mdu block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Occupied;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks;
    int n_fail;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .MDUOp    (MDUOp),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Occupied (Occupied),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for exactly one edge, then drop Start.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        MDUOp = 3'd0;
    endtask

    // Count Busy cycles until Busy drops (bounded); report whether HI/LO held.
    task automatic wait_idle(output int cycles, output bit held);
        logic [31:0] hi0, lo0;
        hi0    = HI;
        lo0    = LO;
        cycles = 0;
        held   = 1'b1;
        while (Busy === 1'b1 && cycles < 100) begin
            if (HI !== hi0 || LO !== lo0) held = 1'b0;
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Start = 1'b0;
        MDUOp = 3'd0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_checks++;
        if (HI !== 32'h0 || LO !== 32'h0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h expected 0/0", HI, LO); end
        n_checks++;
        if (Occupied !== 1'b0) begin n_fail++; $display("FAIL reset_occupied: got %b expected 0", Occupied); end
    endtask

    task automatic test_mult();
        int  cyc;
        bit  held;
        Start = 1'b1; MDUOp = 3'd1; A = 32'hFFFFFFFE; B = 32'd3;
        #1;
        n_checks++;
        if (Occupied !== 1'b1) begin n_fail++; $display("FAIL mult_occupied: got %b expected 1", Occupied); end
        tick();
        Start = 1'b0; MDUOp = 3'd0;
        wait_idle(cyc, held);
        n_checks++;
        if (cyc != 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 5", cyc); end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL mult_hold: HI/LO changed while Busy, got 0 expected 1"); end
        n_checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_result: got %h_%h expected ffffffff_fffffffa", HI, LO); end
    endtask

    task automatic test_multu();
        int cyc;
        bit held;
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(cyc, held);
        n_checks++;
        if (cyc != 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 5", cyc); end
        n_checks++;
        if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin n_fail++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", HI, LO); end
    endtask

    task automatic test_div();
        int cyc;
        bit held;
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc, held);
        n_checks++;
        if (cyc != 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected 10", cyc); end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL div_hold: HI/LO changed while Busy, got 0 expected 1"); end
        n_checks++;
        if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_result: got HI=%h LO=%h expected HI=ffffffff LO=fffffffd", HI, LO); end
        // Divide by zero: full Busy period, nothing written.
        issue(3'd4, 32'd7, 32'd0);
        wait_idle(cyc, held);
        n_checks++;
        if (cyc != 10) begin n_fail++; $display("FAIL divu0_busy_cycles: got %0d expected 10", cyc); end
        n_checks++;
        if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_unchanged: got HI=%h LO=%h expected HI=ffffffff LO=fffffffd", HI, LO); end
        // Unsigned divide with a non-zero divisor.
        issue(3'd4, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc, held);
        n_checks++;
        if (LO !== 32'h7FFFFFFC || HI !== 32'h00000001) begin n_fail++; $display("FAIL divu_result: got HI=%h LO=%h expected HI=00000001 LO=7ffffffc", HI, LO); end
    endtask

    task automatic test_mthi_mtlo();
        issue(3'd5, 32'h12345678, 32'h0);
        n_checks++;
        if (HI !== 32'h12345678 || Busy !== 1'b0) begin n_fail++; $display("FAIL mthi: got HI=%h Busy=%b expected 12345678/0", HI, Busy); end
        issue(3'd6, 32'h9ABCDEF0, 32'h0);
        n_checks++;
        if (LO !== 32'h9ABCDEF0 || HI !== 32'h12345678 || Busy !== 1'b0) begin n_fail++; $display("FAIL mtlo: got HI=%h LO=%h Busy=%b expected 12345678/9abcdef0/0", HI, LO, Busy); end
        // Ops 0 and 7 do nothing.
        issue(3'd0, 32'h11111111, 32'h0);
        issue(3'd7, 32'h22222222, 32'h0);
        n_checks++;
        if (HI !== 32'h12345678 || LO !== 32'h9ABCDEF0 || Busy !== 1'b0) begin n_fail++; $display("FAIL noop_ops: got HI=%h LO=%h Busy=%b expected 12345678/9abcdef0/0", HI, LO, Busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit held;
        issue(3'd1, 32'd5, 32'hFFFFFFF9);   // 5 * -7 = -35
        // mtlo attempt and operand changes while Busy.
        Start = 1'b1; MDUOp = 3'd6; A = 32'hDEADBEEF; B = 32'h0BADF00D;
        #1;
        n_checks++;
        if (Occupied !== 1'b1) begin n_fail++; $display("FAIL busy_occupied: got %b expected 1", Occupied); end
        tick();
        Start = 1'b0; MDUOp = 3'd0;
        n_checks++;
        if (LO !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL busy_mtlo_ignored: got %h expected 9abcdef0", LO); end
        wait_idle(cyc, held);
        n_checks++;
        if (cyc != 4) begin n_fail++; $display("FAIL busy_remaining_cycles: got %0d expected 4", cyc); end
        n_checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFDD) begin n_fail++; $display("FAIL busy_orig_product: got %h_%h expected ffffffff_ffffffdd", HI, LO); end
        // Issue on the first non-busy cycle.
        issue(3'd3, 32'd100, 32'd7);
        n_checks++;
        if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got Busy=%b expected 1", Busy); end
        wait_idle(cyc, held);
        n_checks++;
        if (cyc != 10 || LO !== 32'd14 || HI !== 32'd2) begin n_fail++; $display("FAIL b2b_div: got cyc=%0d HI=%h LO=%h expected 10/00000002/0000000e", cyc, HI, LO); end
    endtask

    task automatic test_div_overflow();
        int cyc;
        bit held;
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc, held);
        n_checks++;
        if (LO !== 32'h80000000 || HI !== 32'h0) begin n_fail++; $display("FAIL div_overflow: got HI=%h LO=%h expected 00000000/80000000", HI, LO); end
    endtask

    task automatic test_reset_abort();
        bit clean;
        issue(3'd3, 32'd100, 32'd7);   // now in Busy cycle 1
        tick();                        // cycle 2
        tick();                        // cycle 3
        tick();                        // cycle 4
        n_checks++;
        if (Busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", Busy); end
        reset = 1'b1;
        Start = 1'b1; MDUOp = 3'd5; A = 32'h0000FFFF;
        tick();
        reset = 1'b0;
        Start = 1'b0; MDUOp = 3'd0;
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin n_fail++; $display("FAIL abort_reset: got Busy=%b HI=%h LO=%h expected 0/0/0", Busy, HI, LO); end
        n_checks++;
        if (Occupied !== 1'b0) begin n_fail++; $display("FAIL abort_occupied: got %b expected 0", Occupied); end
        clean = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) clean = 1'b0;
        end
        n_checks++;
        if (!clean) begin n_fail++; $display("FAIL abort_no_writeback: got HI=%h LO=%h Busy=%b expected 0/0/0", HI, LO, Busy); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mthi_mtlo();
        test_back_to_back();
        test_div_overflow();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
